// File: rtl/islip_voq_pkg.sv
// Shared constants and helpers for the VOQ dequeue path.
//   OBUF_DEPTH    : entries in the per-input output buffer.
//   MAX_VOQ       : widest request/grant vector the helpers accept.
//   MAX_SEL       : index width returned by onehot_to_idx.
//   is_onehot     : 1 when exactly one bit of vec is set.
//   onehot_to_idx : bit position of the set bit (meaningful only for one-hot input).
package islip_voq_pkg;

    localparam int unsigned OBUF_DEPTH = 3;
    localparam int unsigned MAX_VOQ    = 32;
    localparam int unsigned MAX_SEL    = 5;

    function automatic logic is_onehot(input logic [MAX_VOQ-1:0] vec);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < MAX_VOQ; i++) begin
            if (vec[i]) cnt++;
        end
        return (cnt == 32'd1);
    endfunction

    function automatic logic [MAX_SEL-1:0] onehot_to_idx(input logic [MAX_VOQ-1:0] vec);
        logic [MAX_SEL-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_VOQ; i++) begin
            if (vec[i]) idx = i[MAX_SEL-1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/voq_out_buf.sv
// Three-entry in-order register FIFO holding words read from the VOQs,
// each tagged with the VOQ it came from.
//   clk, reset          : clock, asynchronous active-high reset
//   push, push_data/tag : write one tagged word
//   pop                 : consume head (ignored while empty)
//   count               : occupancy 0..3
//   head_valid/data/tag : head entry
module voq_out_buf
    import islip_voq_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SEL_BITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [WIDTH-1:0]    push_data,
    input  logic [SEL_BITS-1:0] push_tag,
    input  logic                pop,
    output logic [1:0]          count,
    output logic                head_valid,
    output logic [WIDTH-1:0]    head_data,
    output logic [SEL_BITS-1:0] head_tag
);

    logic [WIDTH-1:0]    data_q [OBUF_DEPTH];
    logic [SEL_BITS-1:0] tag_q  [OBUF_DEPTH];
    logic [1:0]          wr_ptr;
    logic [1:0]          rd_ptr;
    logic                pop_en;

    // Depth is not a power of two, so pointers wrap explicitly at 2 -> 0.
    function automatic logic [1:0] next_ptr(input logic [1:0] ptr);
        return (ptr == 2'(OBUF_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
    endfunction

    assign pop_en     = pop & (count != 2'd0);
    assign head_valid = (count != 2'd0);
    assign head_data  = data_q[rd_ptr];
    assign head_tag   = tag_q[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < OBUF_DEPTH; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            if (push) begin
                data_q[wr_ptr] <= push_data;
                tag_q[wr_ptr]  <= push_tag;
                wr_ptr         <= next_ptr(wr_ptr);
            end
            if (pop_en) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop_en})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Upstream space check guarantees this never fires.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && (count == 2'(OBUF_DEPTH)) && !pop_en));

endmodule

// File: rtl/voq_dequeue_ctrl.sv
// Per-input dequeue controller between the VOQ FIFO bank and the crossbar.
// Raises requests for non-empty VOQs while output space remains, turns a
// legal one-hot grant into a single FIFO read, captures the FIFO word one
// cycle later and queues it for the crossbar tagged with its VOQ index.
//   clk, reset          : clock, asynchronous active-high reset
//   voq_empty, voq_dout : FIFO status and data (VOQ i at [i*WIDTH +: WIDTH])
//   voq_rd_en           : FIFO read strobes (at most one high)
//   req                 : request vector to the scheduler
//   grant, grant_valid  : scheduler grant
//   grant_accept        : grant consumed this cycle
//   out_data/voq/valid, out_ready : crossbar valid/ready interface
//   err_bad_grant       : sticky illegal-grant flag
module voq_dequeue_ctrl
    import islip_voq_pkg::*;
#(
    parameter int unsigned NUM_VOQ  = 4,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SEL_BITS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_VOQ-1:0]       voq_empty,
    input  logic [NUM_VOQ*WIDTH-1:0] voq_dout,
    output logic [NUM_VOQ-1:0]       voq_rd_en,
    output logic [NUM_VOQ-1:0]       req,
    input  logic [NUM_VOQ-1:0]       grant,
    input  logic                     grant_valid,
    output logic                     grant_accept,
    output logic [WIDTH-1:0]         out_data,
    output logic [SEL_BITS-1:0]      out_voq,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     err_bad_grant
);

    logic [1:0]          buf_count;
    logic                inflight_vld;
    logic [SEL_BITS-1:0] inflight_sel;
    logic                space_ok;
    logic [MAX_VOQ-1:0]  grant_w;
    logic [MAX_SEL-1:0]  grant_idx_w;
    logic [SEL_BITS-1:0] grant_idx;
    logic                legal;
    logic [WIDTH-1:0]    sel_word;

    // Registered state only: a word in flight already owns a buffer slot.
    assign space_ok = ({1'b0, buf_count} + {2'b00, inflight_vld}) < 3'(OBUF_DEPTH);

    always_comb begin
        req = '0;
        if (!reset) req = ~voq_empty & {NUM_VOQ{space_ok}};
    end

    always_comb begin
        grant_w                = '0;
        grant_w[NUM_VOQ-1:0]   = grant;
        grant_idx_w            = onehot_to_idx(grant_w);
        grant_idx              = grant_idx_w[SEL_BITS-1:0];
        legal                  = grant_valid & is_onehot(grant_w) & req[grant_idx];
        grant_accept           = legal;
        voq_rd_en              = legal ? grant : '0;
    end

    always_comb begin
        sel_word = '0;
        for (int unsigned i = 0; i < NUM_VOQ; i++) begin
            if (inflight_sel == i[SEL_BITS-1:0]) sel_word = voq_dout[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_vld  <= 1'b0;
            inflight_sel  <= '0;
            err_bad_grant <= 1'b0;
        end else begin
            inflight_vld <= legal;
            if (legal) inflight_sel <= grant_idx;
            if (grant_valid && !legal) err_bad_grant <= 1'b1;
        end
    end

    voq_out_buf #(
        .WIDTH    (WIDTH),
        .SEL_BITS (SEL_BITS)
    ) u_out_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (inflight_vld),
        .push_data  (sel_word),
        .push_tag   (inflight_sel),
        .pop        (out_ready),
        .count      (buf_count),
        .head_valid (out_valid),
        .head_data  (out_data),
        .head_tag   (out_voq)
    );

endmodule

// File: tb/tb_voq_dequeue_ctrl.sv
// Self-checking bench for voq_dequeue_ctrl with a non-fallthrough FIFO model
// per VOQ and a scoreboard of expected {voq, data} words.
module tb_voq_dequeue_ctrl;

    localparam int unsigned NV = 4;
    localparam int unsigned W  = 32;
    localparam int unsigned SB = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NV-1:0]     voq_empty;
    logic [NV*W-1:0]   voq_dout;
    logic [NV-1:0]     voq_rd_en;
    logic [NV-1:0]     req;
    logic [NV-1:0]     grant = '0;
    logic              grant_valid = 1'b0;
    logic              grant_accept;
    logic [W-1:0]      out_data;
    logic [SB-1:0]     out_voq;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              err_bad_grant;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]  voq;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    // FIFO model: 16 words per VOQ, dout registered on rd_en.
    logic [31:0] mem    [NV][16];
    logic [3:0]  rd_ptr [NV] = '{default: 4'd0};
    logic [3:0]  wr_cnt [NV] = '{default: 4'd0};
    logic [31:0] dout_r [NV] = '{default: 32'd0};

    always #5 clk = ~clk;

    voq_dequeue_ctrl #(
        .NUM_VOQ  (NV),
        .WIDTH    (W),
        .SEL_BITS (SB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .voq_empty     (voq_empty),
        .voq_dout      (voq_dout),
        .voq_rd_en     (voq_rd_en),
        .req           (req),
        .grant         (grant),
        .grant_valid   (grant_valid),
        .grant_accept  (grant_accept),
        .out_data      (out_data),
        .out_voq       (out_voq),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .err_bad_grant (err_bad_grant)
    );

    always_comb begin
        for (int i = 0; i < NV; i++) begin
            voq_dout[i*W +: W] = dout_r[i];
            voq_empty[i]       = (rd_ptr[i] == wr_cnt[i]);
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NV; i++) rd_ptr[i] <= wr_cnt[i];
        end else begin
            for (int i = 0; i < NV; i++) begin
                if (voq_rd_en[i]) begin
                    dout_r[i] <= mem[i][rd_ptr[i]];
                    rd_ptr[i] <= rd_ptr[i] + 4'd1;
                end
            end
        end
    end

    task automatic load(input int v, input logic [31:0] d);
        mem[v][wr_cnt[v]] = d;
        wr_cnt[v] = wr_cnt[v] + 4'd1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output word must match the scoreboard head.
    always begin
        @(negedge clk);
        #3;
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got voq=%0d data=%h expected no word", out_voq, out_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_voq !== mon_e.voq || out_data !== mon_e.data) begin
                    failures++;
                    $display("FAIL sb_word: got voq=%0d data=%h expected voq=%0d data=%h",
                             out_voq, out_data, mon_e.voq, mon_e.data);
                end
            end
        end
    end

    int acc;

    initial begin
        // ---- reset state ----
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_voq", out_voq, 0);
        chk("rst_err", err_bad_grant, 0);
        load(2, 32'hDEAD_0000);
        grant = 4'b0100;
        grant_valid = 1'b1;
        #1;
        chk("rst_req_gated", req, 4'b0000);
        chk("rst_rd_en", voq_rd_en, 4'b0000);
        chk("rst_accept", grant_accept, 0);
        grant_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // ---- single read ----
        @(negedge clk);
        load(2, 32'hA5A5_0001);
        out_ready = 1'b1;
        #1;
        chk("single_req", req, 4'b0100);
        grant = 4'b0100;
        grant_valid = 1'b1;
        exp_q.push_back('{voq: 2'd2, data: 32'hA5A5_0001});
        #1;
        chk("single_rd_en", voq_rd_en, 4'b0100);
        chk("single_accept", grant_accept, 1);
        @(negedge clk);
        grant_valid = 1'b0;
        #1;
        chk("single_t1_valid", out_valid, 0);
        @(negedge clk);
        #1;
        chk("single_t2_valid", out_valid, 1);
        chk("single_t2_data", out_data, 32'hA5A5_0001);
        chk("single_t2_voq", out_voq, 2);
        @(negedge clk);
        #1;
        chk("single_t3_valid", out_valid, 0);

        // ---- streaming 8 words from VOQ0 ----
        for (int k = 0; k < 8; k++) load(0, 32'h0000_0100 + 32'(k));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k < 8) begin
                grant = 4'b0001;
                grant_valid = 1'b1;
                exp_q.push_back('{voq: 2'd0, data: 32'h0000_0100 + 32'(k)});
            end else begin
                grant_valid = 1'b0;
            end
            #1;
            if (k < 8)  chk("stream_accept", grant_accept, 1);
            if (k >= 2) chk("stream_valid", out_valid, 1);
            if (k == 8) chk("stream_req0_drop", req[0], 0);
        end
        @(negedge clk);
        #1;
        chk("stream_end_valid", out_valid, 0);

        // ---- interleave VOQ1, VOQ3, VOQ1 ----
        load(1, 32'h1111_0001);
        load(1, 32'h1111_0002);
        load(3, 32'h3333_0001);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            grant = (k == 1) ? 4'b1000 : 4'b0010;
            grant_valid = 1'b1;
            case (k)
                0:       exp_q.push_back('{voq: 2'd1, data: 32'h1111_0001});
                1:       exp_q.push_back('{voq: 2'd3, data: 32'h3333_0001});
                default: exp_q.push_back('{voq: 2'd1, data: 32'h1111_0002});
            endcase
            #1;
            chk("ilv_accept", grant_accept, 1);
        end
        @(negedge clk);
        grant_valid = 1'b0;
        repeat (4) @(negedge clk);

        // ---- illegal grants ----
        #1;
        chk("ill_err_before", err_bad_grant, 0);
        grant = 4'b0110;
        grant_valid = 1'b1;
        #1;
        chk("ill_multi_rd_en", voq_rd_en, 4'b0000);
        chk("ill_multi_accept", grant_accept, 0);
        @(negedge clk);
        grant = 4'b1000;
        #1;
        chk("ill_err_rise", err_bad_grant, 1);
        chk("ill_empty_rd_en", voq_rd_en, 4'b0000);
        chk("ill_empty_accept", grant_accept, 0);
        @(negedge clk);
        grant_valid = 1'b0;
        #1;
        chk("ill_err_hold", err_bad_grant, 1);

        // ---- backpressure ----
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) load(1, 32'hBB00_0000 + 32'(k));
        for (int k = 0; k < 4; k++) exp_q.push_back('{voq: 2'd1, data: 32'hBB00_0000 + 32'(k)});
        acc = 0;
        grant = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            grant_valid = 1'b1;
            #1;
            if (grant_accept) acc++;
        end
        chk("bp_accepts", acc, 3);
        chk("bp_req_zero", req, 4'b0000);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_release_accept", grant_accept, 0);
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            out_ready = 1'b0;
            #1;
            if (grant_accept) acc++;
        end
        chk("bp_one_more", acc, 1);
        chk("bp_err_hold", err_bad_grant, 1);
        grant_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        chk("bp_drained", exp_q.size(), 0);

        // ---- reset mid-stream: 2 buffered, 1 in flight ----
        out_ready = 1'b0;
        load(0, 32'hC000_0001);
        load(0, 32'hC000_0002);
        load(0, 32'hC000_0003);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            grant = 4'b0001;
            grant_valid = 1'b1;
            #1;
            chk("rms_accept", grant_accept, 1);
        end
        @(negedge clk);
        grant_valid = 1'b0;
        #1;
        chk("rms_pre_valid", out_valid, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("rms_valid_async", out_valid, 0);
        chk("rms_data_async", out_data, 0);
        chk("rms_voq_async", out_voq, 0);
        chk("rms_err_clear", err_bad_grant, 0);
        load(3, 32'h3333_0009);
        grant = 4'b1000;
        grant_valid = 1'b1;
        #1;
        chk("rms_req_reset", req, 4'b0000);
        chk("rms_rd_en_reset", voq_rd_en, 4'b0000);
        chk("rms_accept_reset", grant_accept, 0);
        grant_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("rms_no_stale", out_valid, 0);
        end

        repeat (2) @(negedge clk);
        chk("final_sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/voq_dequeue_ctrl.md
Name: voq_dequeue_ctrl

Overview:
- Sits directly downstream of the per-input bank of NUM_VOQ small_fifo VOQs (non-fallthrough: dout is valid one cycle after rd_en).
- Builds the request vector for the iSLIP scheduler and turns each accepted one-hot grant into a single VOQ read.
- Captures the delayed FIFO data and presents it to the crossbar on a valid/ready interface, tagged with its VOQ index.

Parameters:
- NUM_VOQ, 4, number of VOQs (outputs) served by this input port.
- WIDTH, 32, data word width; must equal the VOQ FIFO WIDTH.
- SEL_BITS, 2, index width; equals clog2(NUM_VOQ).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- voq_empty  in  NUM_VOQ  empty flags from the VOQ FIFOs.
- voq_dout  in  NUM_VOQ*WIDTH  FIFO dout words; VOQ i occupies bits [i*WIDTH +: WIDTH].
- voq_rd_en  out  NUM_VOQ  FIFO read strobes; at most one bit high.
- req  out  NUM_VOQ  request vector to the scheduler.
- grant  in  NUM_VOQ  one-hot grant from the scheduler.
- grant_valid  in  1  qualifies grant.
- grant_accept  out  1  the grant was consumed this cycle.
- out_data  out  WIDTH  head word of the output buffer.
- out_voq  out  SEL_BITS  VOQ index of out_data.
- out_valid  out  1  out_data/out_voq are valid.
- out_ready  in  1  crossbar accepts the head word.
- err_bad_grant  out  1  sticky flag for an illegal grant.

Behaviour:
- Space check: space_ok = (buf_count + inflight_vld) < OBUF_DEPTH, where OBUF_DEPTH = 3. It uses registered state only; there is no combinational path from out_ready.
- Requests: req[i] = ~voq_empty[i] & space_ok & ~reset.
- Legal grant: grant_valid, grant is exactly one-hot, and req[idx] = 1. Only then: accept = 1 and voq_rd_en = grant, combinationally in the same cycle T.
- Otherwise accept = 0 and voq_rd_en = 0. grant_valid with an illegal grant (zero-hot, multi-hot, or non-requesting VOQ) also sets err_bad_grant, which stays set until reset.
- Edge ending T: inflight_vld <= 1, inflight_sel <= idx. If there is no accept, inflight_vld <= 0.
- Cycle T+1: voq_dout[inflight_sel] holds the word. At the edge ending T+1 it is written into the output buffer with tag inflight_sel.
- Latency: grant cycle T gives out_valid at cycle T+2 when the buffer was empty.
- Output buffer: 3-entry in-order register FIFO.
  - out_valid = (buf_count != 0); out_data/out_voq show the head entry.
  - Pop on out_valid & out_ready.
  - A push and a pop in the same cycle leave buf_count unchanged.
  - Overflow is impossible by construction; a simulation-only assertion flags push when buf_count == 3 and there is no pop.
- Throughput: one word per cycle sustained when grants are continuous and out_ready = 1.
- Empty timing: FIFO depth updates at the read edge, so a VOQ holding one word drops its req in T+1 with no extra masking.
- Wrap-around: buffer pointers are 2 bits and wrap modulo 3, so explicit wrap logic is required.
- Reset:
  - Asynchronous; clears inflight_vld, buffer pointers, buf_count and err_bad_grant.
  - out_valid = 0, out_data = 0, out_voq = 0.
  - While reset is asserted, req = 0, voq_rd_en = 0 and grant_accept = 0.
  - A read in flight when reset asserts is dropped; the FIFO is reset by the same signal.

Decomposition:
- Package islip_voq_pkg holds:
  - constant OBUF_DEPTH = 3;
  - function is_onehot(vec);
  - function onehot_to_idx(vec).
- Sub-module voq_out_buf holds the 3-entry buffer: push/tag/data in, pop, count, head out, async reset.
- The top level holds request/grant logic, the inflight register and the dout mux.

Test Plan:
- Single read: VOQ2 holds 0xA5A5_0001; at T, grant = 4'b0100 with grant_valid = 1.
  - Required: voq_rd_en = 4'b0100 and grant_accept = 1 at T.
  - Required: out_valid = 1, out_data = 0xA5A5_0001, out_voq = 2 at T+2.
- Streaming: VOQ0 holds 8 words, out_ready = 1, grant = 4'b0001 every cycle.
  - Required: 8 accepts in 8 consecutive cycles; words appear in order over 8 consecutive cycles starting at T+2.
  - Required: req[0] = 0 from the cycle after the 8th read.
- Backpressure: out_ready = 0 with continuous grants.
  - Required: exactly 3 accepts, then req = 0 while buf_count = 3.
  - Required: raising out_ready for 1 cycle re-enables exactly one accept.
- Illegal grants: grant = 4'b0110 with grant_valid; then grant to an empty VOQ3.
  - Required: no voq_rd_en and grant_accept = 0 in both cases.
  - Required: err_bad_grant rises after the first and holds until reset.
- Interleave: grants VOQ1, VOQ3, VOQ1 back-to-back.
  - Required: outputs arrive with out_voq sequence 1, 3, 1 and matching data.
- Reset mid-stream: assert reset asynchronously with 2 words buffered and 1 in flight.
  - Required: out_valid = 0 immediately, req = 0 during reset, no stale word after release.
